// File: rtl/uart_rx_buffered.sv
// Parametrised UART receiver: 2-FF synchroniser, glitch-rejecting start check, show-ahead FIFO, error pulses.
// Define UART_RX_MAJORITY_EN to take every sample as a 2-of-3 vote (requires CLK_PER_BIT >= 6).
module uart_rx_buffered #(
    parameter int CLK_PER_BIT = 868,
    parameter int CNT_WIDTH   = 10,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int FIFO_AW     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic [FIFO_AW:0]     fifo_count,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int HALF  = CLK_PER_BIT / 2;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_WIDTH-1:0] BIT_END = CNT_WIDTH'(CLK_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_WIDTH-1:0] START_END = CNT_WIDTH'(HALF);
`else
    localparam logic [CNT_WIDTH-1:0] START_END = CNT_WIDTH'(HALF - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bad;
    logic                 push_req;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_bit;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Decision is made one cycle late, voting over the target-1, target and target+1 samples.
    logic [1:0] rx_hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_hist <= 2'b11;
        end else begin
            rx_hist <= {rx_hist[0], rx_s};
        end
    end

    assign rx_bit = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_s) | (rx_hist[0] & rx_s);
`else
    assign rx_bit = rx_s;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_bad    <= 1'b0;
            push_req   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            push_req   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= S_START;
                end
                S_START: begin
                    if (cnt == START_END) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        par_bad <= 1'b0;
                        state   <= rx_bit ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_END) begin
                        cnt   <= '0;
                        shift <= {rx_bit, shift[DATA_BITS-1:1]};
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            state <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt == BIT_END) begin
                        cnt     <= '0;
                        par_bad <= ((^shift) ^ rx_bit) != (PARITY_MODE == 2);
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_END) begin
                        cnt        <= '0;
                        state      <= S_IDLE;
                        push_req   <= rx_bit && !par_bad;
                        frame_err  <= !rx_bit;
                        parity_err <= par_bad;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The shift register stays stable until the next frame's data bits, so it feeds the FIFO directly.
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic                 pop;
    logic                 full;
    logic                 push_ok;

    assign rd_valid = (fifo_count != '0);
    assign full     = (fifo_count == (FIFO_AW + 1)'(DEPTH));
    assign pop      = rd_en && rd_valid;
    assign push_ok  = push_req && (!full || pop);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
        end else begin
            overrun <= push_req && full && !pop;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; rd_data is masked while empty, so stale words never escape.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shift;
    end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: three instances (8N1, 8E1, 8O1; depth 4) checked against a queue model.
module tb_uart_rx_buffered;

    localparam int CPB   = 16;
    localparam int NU    = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    logic rx_a    [NU];
    logic rd_en_a [NU];
    wire  [7:0] rd_data_w  [NU];
    wire        rd_valid_w [NU];
    wire  [2:0] cnt_w      [NU];
    wire        fe_w       [NU];
    wire        pe_w       [NU];
    wire        ov_w       [NU];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        uart_rx_buffered #(
            .CLK_PER_BIT(CPB),
            .CNT_WIDTH  (5),
            .DATA_BITS  (8),
            .PARITY_MODE(g),
            .FIFO_AW    (2)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .uart_rx   (rx_a[g]),
            .rd_en     (rd_en_a[g]),
            .rd_data   (rd_data_w[g]),
            .rd_valid  (rd_valid_w[g]),
            .fifo_count(cnt_w[g]),
            .frame_err (fe_w[g]),
            .parity_err(pe_w[g]),
            .overrun   (ov_w[g])
        );
    end

    int n_vec  = 0;
    int n_miss = 0;

    // Pulse counters, sampled away from the active edge.
    int fe_cnt [NU];
    int pe_cnt [NU];
    int ov_cnt [NU];

    always @(negedge clk) begin
        for (int i = 0; i < NU; i++) begin
            if (fe_w[i] === 1'b1) fe_cnt[i]++;
            if (pe_w[i] === 1'b1) pe_cnt[i]++;
            if (ov_w[i] === 1'b1) ov_cnt[i]++;
        end
    end

    // Reference model: a circular list of accepted bytes per instance.
    logic [7:0] m_mem  [NU][DEPTH];
    int         m_head [NU];
    int         m_len  [NU];

    task automatic model_clear();
        for (int i = 0; i < NU; i++) begin
            m_head[i] = 0;
            m_len[i]  = 0;
        end
    endtask

    task automatic model_frame(input int u, input logic [7:0] d, input bit flip, input bit stop,
                               output int efe, output int epe, output int eov);
        bit perr;
        bit push;
        perr = (u != 0) && flip;
        efe  = stop ? 0 : 1;
        epe  = perr ? 1 : 0;
        push = stop && !perr;
        eov  = (push && m_len[u] == DEPTH) ? 1 : 0;
        if (push && eov == 0) begin
            m_mem[u][(m_head[u] + m_len[u]) % DEPTH] = d;
            m_len[u]++;
        end
    endtask

    task automatic send_bit(input int u, input logic b);
        rx_a[u] = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input int u, input logic [7:0] d, input bit flip, input bit stop, input int gap);
        logic p;
        send_bit(u, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(u, d[i]);
        if (u != 0) begin
            p = (u == 1) ? ^d : ~^d;
            send_bit(u, p ^ flip);
        end
        send_bit(u, stop);
        rx_a[u] = 1'b1;
        idle(gap);
    endtask

    // Sends one frame and compares pulses, occupancy and head against the model.
    task automatic run_frame(input int u, input logic [7:0] d, input bit flip, input bit stop, input int gap);
        int fe0, pe0, ov0, efe, epe, eov;
        fe0 = fe_cnt[u]; pe0 = pe_cnt[u]; ov0 = ov_cnt[u];
        model_frame(u, d, flip, stop, efe, epe, eov);
        drive_frame(u, d, flip, stop, gap);
        n_vec++;
        if (fe_cnt[u] - fe0 !== efe) begin
            n_miss++; $display("FAIL frame_err u%0d d=%02h: got %0d pulses, want %0d", u, d, fe_cnt[u] - fe0, efe);
        end
        n_vec++;
        if (pe_cnt[u] - pe0 !== epe) begin
            n_miss++; $display("FAIL parity_err u%0d d=%02h: got %0d pulses, want %0d", u, d, pe_cnt[u] - pe0, epe);
        end
        n_vec++;
        if (ov_cnt[u] - ov0 !== eov) begin
            n_miss++; $display("FAIL overrun u%0d d=%02h: got %0d pulses, want %0d", u, d, ov_cnt[u] - ov0, eov);
        end
        n_vec++;
        if (int'(cnt_w[u]) !== m_len[u]) begin
            n_miss++; $display("FAIL fifo_count u%0d d=%02h: got %0d, want %0d", u, d, cnt_w[u], m_len[u]);
        end
        n_vec++;
        if (rd_valid_w[u] !== (m_len[u] != 0)) begin
            n_miss++; $display("FAIL rd_valid u%0d d=%02h: got %b, want %b", u, d, rd_valid_w[u], m_len[u] != 0);
        end
        if (m_len[u] != 0) begin
            n_vec++;
            if (rd_data_w[u] !== m_mem[u][m_head[u]]) begin
                n_miss++; $display("FAIL head u%0d: got %02h, want %02h", u, rd_data_w[u], m_mem[u][m_head[u]]);
            end
        end
    endtask

    // One-cycle rd_en pulse; on an empty FIFO it must be ignored.
    task automatic do_pop(input int u);
        if (m_len[u] != 0) begin
            n_vec++;
            if (rd_data_w[u] !== m_mem[u][m_head[u]]) begin
                n_miss++; $display("FAIL pop_data u%0d: got %02h, want %02h", u, rd_data_w[u], m_mem[u][m_head[u]]);
            end
        end
        rd_en_a[u] = 1'b1;
        @(posedge clk);
        #1;
        rd_en_a[u] = 1'b0;
        if (m_len[u] != 0) begin
            m_head[u] = (m_head[u] + 1) % DEPTH;
            m_len[u]--;
        end
        n_vec++;
        if (int'(cnt_w[u]) !== m_len[u] || rd_valid_w[u] !== (m_len[u] != 0)) begin
            n_miss++; $display("FAIL pop_count u%0d: got count %0d valid %b, want %0d", u, cnt_w[u], rd_valid_w[u], m_len[u]);
        end
    endtask

    task automatic drain(input int u);
        while (m_len[u] != 0) do_pop(u);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_clear();
        for (int i = 0; i < NU; i++) begin
            rx_a[i] = 1'b1; rd_en_a[i] = 1'b0;
            fe_cnt[i] = 0; pe_cnt[i] = 0; ov_cnt[i] = 0;
        end
        idle(4);
        for (int i = 0; i < NU; i++) begin
            n_vec++;
            if (rd_valid_w[i] !== 1'b0 || cnt_w[i] !== 3'd0 || rd_data_w[i] !== 8'h00 ||
                fe_w[i] !== 1'b0 || pe_w[i] !== 1'b0 || ov_w[i] !== 1'b0) begin
                n_miss++;
                $display("FAIL reset u%0d: got valid=%b count=%0d data=%02h fe=%b pe=%b ov=%b, want all zero",
                         i, rd_valid_w[i], cnt_w[i], rd_data_w[i], fe_w[i], pe_w[i], ov_w[i]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        idle(4);
    endtask

    task automatic test_basic();
        run_frame(0, 8'hA5, 1'b0, 1'b1, 16);
        do_pop(0);
        do_pop(0);
    endtask

    task automatic test_glitch();
        int fe0, pe0, ov0;
        fe0 = fe_cnt[0]; pe0 = pe_cnt[0]; ov0 = ov_cnt[0];
        rx_a[0] = 1'b0;
        idle(4);
        rx_a[0] = 1'b1;
        idle(20);
        n_vec++;
        if (cnt_w[0] !== 3'd0 || fe_cnt[0] != fe0 || pe_cnt[0] != pe0 || ov_cnt[0] != ov0) begin
            n_miss++; $display("FAIL glitch: got count %0d, pulses fe/pe/ov %0d/%0d/%0d, want nothing",
                               cnt_w[0], fe_cnt[0] - fe0, pe_cnt[0] - pe0, ov_cnt[0] - ov0);
        end
        run_frame(0, 8'h3C, 1'b0, 1'b1, 16);
        drain(0);
    endtask

    task automatic test_errors();
        int         tu [7] = '{1, 1, 2, 2, 0, 0, 1};
        logic [7:0] td [7] = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h55, 8'h12, 8'h5A};
        bit         tf [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        bit         ts [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) run_frame(tu[i], td[i], tf[i], ts[i], 16);
        for (int i = 0; i < NU; i++) drain(i);
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) run_frame(0, 8'(i), 1'b0, 1'b1, 16);
        drain(0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) run_frame(1, 8'($urandom_range(0, 255)), 1'b0, 1'b1, 0);
        idle(16);
        drain(1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) run_frame(0, 8'(8'hC0 + i), 1'b0, 1'b1, 16);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b0);
        reset = 1'b1;
        #1;
        for (int i = 0; i < NU; i++) begin
            n_vec++;
            if (cnt_w[i] !== 3'd0 || rd_valid_w[i] !== 1'b0) begin
                n_miss++; $display("FAIL reset_mid u%0d: got count %0d valid %b, want 0 0", i, cnt_w[i], rd_valid_w[i]);
            end
        end
        rx_a[0] = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(20);
        run_frame(0, 8'h7E, 1'b0, 1'b1, 16);
        drain(0);
    endtask

    task automatic test_random();
        int u;
        for (int n = 0; n < 40; n++) begin
            u = int'($urandom_range(0, NU - 1));
            run_frame(u, 8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0),
                      ($urandom_range(0, 6) != 0), 16);
            for (int k = int'($urandom_range(0, 2)); k > 0; k--) do_pop(int'($urandom_range(0, NU - 1)));
        end
        for (int i = 0; i < NU; i++) drain(i);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_errors();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
